// File: rtl/fadd_wb.sv
// fadd_wb: writeback stage behind the pipelined fadd unit.
//
// fadd carries no valid or tag. This block tracks each issued add with a
// {valid, tag} shift pipeline matched to the fadd latency. It captures the
// fadd result on the matching cycle into a small FIFO. It then presents
// tagged results on a valid/ready writeback port.
//
// Issue is throttled by an occupancy credit that counts FIFO entries plus
// in-flight adds. Because of that credit, a result that fadd cannot stall
// always finds a free FIFO slot.
//
// Build option:
//   FADD_WB_FTZ_EN - when defined, a denormal fadd result is flushed to a
//                    signed zero as it enters the FIFO. NaN, Inf and zero
//                    are unaffected. When undefined, results are stored
//                    bit-exact.
module fadd_wb #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [31:0]                fadd_s,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  // Value written into the FIFO for a given fadd result; optionally flushes
  // denormals (exponent 0, non-zero mantissa) to a zero of the same sign.
  function automatic logic [31:0] store_value(input logic [31:0] s);
`ifdef FADD_WB_FTZ_EN
    if ((s[30:23] == 8'h00) && (s[22:0] != 23'h0)) begin
      return {s[31], 31'b0};
    end
    return s;
`else
    return s;
`endif
  endfunction

  // Handshake events
  logic fire;
  logic pop;
  logic push;

  // Tag tracking pipeline: stage 0 is loaded on the issue edge and the last
  // stage lines up with the fadd_s value of the same add.
  logic [LATENCY:0] pv_q;
  logic [LATENCY:0] pv_d;
  logic [TAG_W-1:0] pt_q [0:LATENCY];
  logic [TAG_W-1:0] pt_d [0:LATENCY];

  // Result FIFO storage and control
  logic [31:0]      mem_data_q [0:DEPTH-1];
  logic [TAG_W-1:0] mem_tag_q  [0:DEPTH-1];
  logic [31:0]      wr_data_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [OCC_W-1:0] cnt_q;
  logic [OCC_W-1:0] cnt_d;

  // Credit counter: FIFO entries plus adds still inside fadd
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Ready/valid come straight from registers so the handshake inputs never
  // feed back combinationally into them.
  assign issue_ready = (occ_q < DEPTH_OCC);
  assign out_valid   = (cnt_q != '0);
  assign occupancy   = occ_q;

  assign fire = issue_valid & issue_ready;
  assign pop  = out_valid & out_ready;
  assign push = pv_q[LATENCY];

  // The head is gated by out_valid so the port reads zero whenever the FIFO
  // is empty (including straight out of reset) without resetting storage.
  assign out_data = out_valid ? mem_data_q[rd_ptr_q] : 32'h0;
  assign out_tag  = out_valid ? mem_tag_q[rd_ptr_q]  : '0;

  // Next state of the tag pipeline: shifts every cycle, no stall
  always_comb begin
    pv_d = {pv_q[LATENCY-1:0], fire};
    for (int k = 0; k <= LATENCY; k++) begin
      pt_d[k] = '0;
    end
    pt_d[0] = issue_tag;
    for (int k = 1; k <= LATENCY; k++) begin
      pt_d[k] = pt_q[k-1];
    end
  end

  // Next state of FIFO pointers, fill count and write data
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    wr_data_d = store_value(fadd_s);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + OCC_W'(1);
      2'b01:   cnt_d = cnt_q - OCC_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Next credit count: a push only moves an entry from in-flight to FIFO
  always_comb begin
    case ({fire, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state: valids, pointers and counts, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      pv_q     <= pv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
    end
  end

  // Datapath state: tags ride along with their valids, no reset needed
  always_ff @(posedge clk) begin
    for (int k = 0; k <= LATENCY; k++) begin
      pt_q[k] <= pt_d[k];
    end
  end

  // FIFO storage written at the tail on a push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= wr_data_d;
      mem_tag_q[wr_ptr_q]  <= pt_q[LATENCY];
    end
  end

endmodule

// File: tb/tb_fadd_wb.sv
// Testbench for fadd_wb: directed steps with a scoreboard queue.
module tb_fadd_wb;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [TAG_W-1:0]       issue_tag;
  logic [31:0]            fadd_s;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic [TAG_W-1:0]       out_tag;
  logic [$clog2(DEPTH):0] occupancy;

  // Operand proxy: the value the fadd model will return for this cycle
  logic [31:0] issue_data;
  logic [31:0] op_val;
  logic [31:0] fpipe [0:LATENCY];

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    int               rdy_at;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   occ_m    = 0;
  int   nfire    = 0;
  int   tagc     = 0;

  fadd_wb #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .fadd_s(fadd_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Upstream fadd model: non-stallable, no reset, result LATENCY edges later
  always @(posedge clk) begin
    fpipe[0] <= op_val;
    for (int k = 1; k <= LATENCY; k++) fpipe[k] <= fpipe[k-1];
  end
  assign fadd_s = fpipe[LATENCY];

  function automatic logic [31:0] exp_store(input logic [31:0] s);
`ifdef FADD_WB_FTZ_EN
    if (s[30:23] == 8'h00 && s[22:0] != 23'h0) return {s[31], 31'b0};
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the scoreboard, record the
  // handshakes that will happen at the coming edge, then advance.
  task automatic step();
    logic ev;
    logic fire;
    logic pop;
    ev = (sb.size() > 0) && (sb[0].rdy_at <= cyc);
    chk("out_valid", out_valid, ev);
    chk("occupancy", occupancy, occ_m);
    chk("issue_ready", issue_ready, (occ_m < DEPTH));
    if (ev) begin
      chk("out_data", out_data, sb[0].d);
      chk("out_tag", out_tag, sb[0].t);
    end
    fire = issue_valid && issue_ready;
    pop  = out_valid && out_ready;
    op_val = fire ? issue_data : $urandom;
    if (pop) begin
      if (sb.size() > 0) void'(sb.pop_front());
      else chk("pop_on_empty", 1'b1, 1'b0);
      occ_m--;
    end
    if (fire) begin
      sb.push_back('{exp_store(issue_data), issue_tag, cyc + LATENCY + 2});
      occ_m++;
      nfire++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_occupancy"}, occupancy, 0);
    chk({tag, "_issue_ready"}, issue_ready, 1'b1);
    chk({tag, "_out_data"}, out_data, 32'h0);
    chk({tag, "_out_tag"}, out_tag, 0);
  endtask

  initial begin
    int f0;
    int n;
    rst_n = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
    issue_tag = '0; issue_data = 32'h0; op_val = 32'h0;
    #1;
    reset_checks("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single add: visible after E0+3, then popped
    out_ready = 1'b1;
    issue_valid = 1'b1; issue_tag = 5'h03; issue_data = 32'h40400000;
    step();
    issue_valid = 1'b0;
    step(); step();
    chk("single_not_yet", out_valid, 1'b0);
    step();
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 32'h40400000);
    chk("single_tag", out_tag, 5'h03);
    step(); step();
    chk("single_occ_zero", occupancy, 0);

    // Backpressure: six back-to-back requests, only four accepted
    out_ready = 1'b0;
    f0 = nfire;
    for (int i = 1; i <= 6; i++) begin
      issue_valid = 1'b1; issue_tag = TAG_W'(i); issue_data = $urandom;
      step();
    end
    chk("bp_fires", nfire - f0, 4);
    chk("bp_ready_low", issue_ready, 1'b0);
    issue_valid = 1'b0;
    repeat (4) step();
    chk("bp_head_tag", out_tag, 5'h01);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue_valid = (i >= 2); issue_tag = TAG_W'(7 + i); issue_data = $urandom;
      step();
    end
    issue_valid = 1'b0;
    repeat (6) step();

    // Fill to full, then 20 random cycles of concurrent issue and drain
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1; issue_tag = TAG_W'(tagc++); issue_data = $urandom;
      step();
    end
    chk("full_occ", occupancy, DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      issue_valid = 1'b1; issue_tag = TAG_W'(tagc++); issue_data = $urandom;
      step();
    end
    issue_valid = 1'b0;
    repeat (8) step();
    chk("full_drained", sb.size(), 0);

    // Reset with three adds in flight; later fadd outputs must be ignored
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_tag = TAG_W'(tagc++); issue_data = $urandom;
      step();
    end
    issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    sb.delete();
    occ_m = 0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("midrst_occ", occupancy, 0);

    // Denormal and NaN handling at push
    out_ready = 1'b0;
    issue_valid = 1'b1; issue_tag = 5'h11; issue_data = 32'h80000001;
    step();
    issue_valid = 1'b1; issue_tag = 5'h12; issue_data = 32'h7fc00000;
    step();
    issue_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("ftz_wait", out_valid, 1'b1);
`ifdef FADD_WB_FTZ_EN
    chk("ftz_denorm", out_data, 32'h80000000);
`else
    chk("ftz_denorm", out_data, 32'h80000001);
`endif
    out_ready = 1'b1;
    step();
    chk("ftz_nan", out_data, 32'h7fc00000);
    chk("ftz_nan_tag", out_tag, 5'h12);
    repeat (3) step();

    // Pointer wrap: 3*DEPTH adds with random out_ready
    f0 = nfire;
    n = 0;
    while ((nfire - f0) < 3 * DEPTH && n < 300) begin
      issue_valid = 1'b1; issue_tag = TAG_W'(tagc); issue_data = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      if (issue_ready) tagc++;
      step();
      n++;
    end
    chk("wrap_fires", nfire - f0, 3 * DEPTH);
    issue_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("wrap_drained", sb.size(), 0);
    chk("final_occ", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
